// File: rtl/vip_cfg_arbiter.sv
// Round-robin burst arbiter onto one Avalon-MM config write port; 1-cycle handshake-to-write latency.
// req_ready is combinational and granted per burst; waitrequest stalls the held beat, a watchdog frees stuck grants.
module vip_cfg_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*9-1:0]  req_addr,
  input  logic [N*32-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic [8:0]      address,
  output logic            write,
  output logic [31:0]     writedata,
  input  logic            waitrequest,
  output logic            busy,
  output logic [2:0]      grant_id,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [11:0] CNT_LAST = 12'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [11:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        write_q, write_d;
  logic        busy_q, busy_d;
  logic        terr_q, terr_d;
  logic [8:0]  address_q, address_d;
  logic [31:0] wdata_q, wdata_d;

  logic        found, gnt_valid, hs, beat_last, inc, expire;
  logic [2:0]  winner, sel, rr_next;
  logic [8:0]  beat_addr;
  logic [31:0] beat_data;

  // Outer loop over search distance from rr_ptr, so the nearest valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_valid[i] && (i == (int'(rr_ptr_q) + k) % N)) begin
          found  = 1'b1;
          winner = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel       = (state_q == IDLE) ? winner : grant_id_q;
    beat_addr = '0;
    beat_data = '0;
    beat_last = 1'b0;
    gnt_valid = 1'b0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == 3'(i)) begin
        beat_addr = req_addr[i*9 +: 9];
        beat_data = req_data[i*32 +: 32];
        beat_last = req_last[i];
      end
      if (grant_id_q == 3'(i)) gnt_valid = req_valid[i];
      req_ready[i] = (((state_q == IDLE) && found) || (state_q == HOLD)) && (sel == 3'(i));
    end
    hs      = |(req_valid & req_ready);
    rr_next = (grant_id_q == 3'(N - 1)) ? 3'd0 : grant_id_q + 3'd1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    write_d    = write_q;
    busy_d     = busy_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    terr_d     = 1'b0;
    inc        = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          address_d  = beat_addr;
          wdata_d    = beat_data;
          last_d     = beat_last;
          write_d    = 1'b1;
          busy_d     = 1'b1;
          grant_id_d = winner;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (!waitrequest) begin
          write_d = 1'b0;
          if (last_q) begin
            busy_d   = 1'b0;
            rr_ptr_d = rr_next;
            state_d  = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else begin
          inc = 1'b1;
        end
      end
      HOLD: begin
        if (hs) begin
          address_d = beat_addr;
          wdata_d   = beat_data;
          last_d    = beat_last;
          write_d   = 1'b1;
          state_d   = XFER;
        end else if (!gnt_valid) begin
          inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // inc is never set on an accepting or handshaking cycle, so those always win over expiry.
    expire = inc && (cnt_q == CNT_LAST);
    if (expire) begin
      write_d  = 1'b0;
      terr_d   = 1'b1;
      busy_d   = 1'b0;
      rr_ptr_d = rr_next;
      state_d  = IDLE;
    end
    if ((state_d != state_q) || hs) cnt_d = '0;
    else if (inc)                   cnt_d = cnt_q + 12'd1;
    else                            cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
    end
  end

  assign address     = address_q;
  assign write       = write_q;
  assign writedata   = wdata_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_vip_cfg_arbiter.sv
// Bench for vip_cfg_arbiter: per-requester burst queues, a burst-level round-robin model
// feeding an expected-write scoreboard, and a monitor that checks every accepted Avalon write.
module tb_vip_cfg_arbiter;

  typedef struct packed {
    logic [2:0]  id;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid, req_last, req_ready;
  logic [26:0] req_addr;
  logic [95:0] req_data;
  logic [8:0]  address;
  logic        write, waitrequest, busy, timeout_err;
  logic [31:0] writedata;
  logic [2:0]  grant_id;

  int    checks = 0;
  int    errors = 0;
  int    model_ptr = 0;
  beat_t rq[3][$];
  beat_t exp_q[$];
  logic  prev_acc = 1'b0;

  vip_cfg_arbiter #(.N(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .address(address), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int id, input int a, input int d, input bit l);
    beat_t b;
    b.id = 3'(id); b.addr = 9'(a); b.data = 32'(d); b.last = l;
    return b;
  endfunction

  task automatic set_req(input int i, input beat_t b);
    req_valid[i]        = 1'b1;
    req_last[i]         = b.last;
    req_addr[i*9 +: 9]  = b.addr;
    req_data[i*32 +: 32] = b.data;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted write must match the next expected beat; also burst lockout and write-low gap.
  always @(negedge clk) begin
    beat_t e;
    if (reset_n) begin
      if (busy) chk("ready_lock", {29'd0, req_ready & ~(3'b001 << grant_id)}, 32'd0);
      if (prev_acc) chk("write_gap", {31'd0, write}, 32'd0);
      if (write && !waitrequest) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {23'd0, address}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          chk("beat_id", {29'd0, grant_id}, {29'd0, e.id});
          chk("beat_addr", {23'd0, address}, {23'd0, e.addr});
          chk("beat_data", writedata, e.data);
        end
      end
      prev_acc = write && !waitrequest;
    end else begin
      prev_acc = 1'b0;
    end
  end

  // Model works on whole bursts: all queued requesters stay valid, so grants follow plain round robin.
  task automatic run(input int max_gap, input int stall_pct,
                     output int n_hi, output int first_hi, output int last_hi);
    beat_t    m[3][$];
    beat_t    b;
    int       p, gap[3], cyc, streak;
    bit       fnd;
    logic [2:0] hs;
    for (int i = 0; i < 3; i++) m[i] = rq[i];
    while (m[0].size() + m[1].size() + m[2].size() > 0) begin
      fnd = 0; p = 0;
      for (int k = 0; k < 3; k++)
        if (!fnd && m[(model_ptr + k) % 3].size() > 0) begin fnd = 1; p = (model_ptr + k) % 3; end
      do begin
        b = m[p].pop_front();
        b.id = 3'(p);
        exp_q.push_back(b);
      end while (!b.last);
      model_ptr = (p + 1) % 3;
    end
    gap = '{0, 0, 0};
    cyc = 0; streak = 0; n_hi = 0; first_hi = -1; last_hi = -1;
    while ((rq[0].size() + rq[1].size() + rq[2].size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
      for (int i = 0; i < 3; i++)
        if (rq[i].size() > 0 && gap[i] == 0) set_req(i, rq[i][0]);
        else req_valid[i] = 1'b0;
      if (streak >= 4) waitrequest = 1'b0;
      else waitrequest = ($urandom_range(0, 99) < stall_pct);
      streak = waitrequest ? streak + 1 : 0;
      @(negedge clk);
      hs = req_valid & req_ready;
      if (write) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc;
        last_hi = cyc;
      end
      tick();
      for (int i = 0; i < 3; i++)
        if (hs[i]) begin
          b = rq[i].pop_front();
          gap[i] = b.last ? 0 : $urandom_range(0, max_gap);
        end else if (gap[i] > 0) gap[i]--;
      cyc++;
    end
    chk("run_completed", {31'd0, cyc < 3000}, 32'd1);
    req_valid = '0;
    waitrequest = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, f, l, nb, len;
    reset_n = 1'b0; req_valid = '0; req_last = '0; req_addr = '0; req_data = '0; waitrequest = 1'b0;
    #1;
    chk("rst_write", {31'd0, write}, 0);
    chk("rst_address", {23'd0, address}, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_grant_id", {29'd0, grant_id}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    chk("rst_ready", {29'd0, req_ready}, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single beat
    set_req(0, mk(0, 'h1E, 1, 1));
    exp_q.push_back(mk(0, 'h1E, 1, 1));
    #1;
    chk("single_ready", {29'd0, req_ready}, 32'b001);
    tick();
    req_valid = '0;
    chk("single_write", {31'd0, write}, 1);
    chk("single_addr", {23'd0, address}, 'h1E);
    chk("single_busy", {31'd0, busy}, 1);
    tick();
    chk("single_write_off", {31'd0, write}, 0);
    chk("single_busy_off", {31'd0, busy}, 0);
    model_ptr = 1;

    // Round robin with continuous one-beat bursts: write every other cycle
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++) rq[i].push_back(mk(i, 16 * i + j, 'h100 * i + j, 1));
    run(0, 0, n, f, l);
    chk("rr_write_count", n, 6);
    chk("rr_write_span", l - f, 10);

    // Burst lock: requester 1 three-beat burst while requester 0 waits
    rq[1].push_back(mk(1, 3, 'hA3, 0));
    rq[1].push_back(mk(1, 4, 'hA4, 0));
    rq[1].push_back(mk(1, 0, 'hA0, 1));
    rq[0].push_back(mk(0, 'h55, 'hB5, 1));
    run(0, 0, n, f, l);
    chk("lock_write_count", n, 4);

    // Waitrequest stall for 10 cycles
    set_req(2, mk(2, 'h0C7, 'hDEADBEEF, 1));
    exp_q.push_back(mk(2, 'h0C7, 'hDEADBEEF, 1));
    waitrequest = 1'b1;
    tick();
    req_valid = '0;
    for (int k = 0; k <= 10; k++) begin
      chk("stall_write", {31'd0, write}, 1);
      chk("stall_addr", {23'd0, address}, 'h0C7);
      chk("stall_data", writedata, 'hDEADBEEF);
      waitrequest = (k < 10);
      if (k < 10) tick();
    end
    tick();
    chk("stall_release", {31'd0, write}, 0);
    model_ptr = 0;

    // Watchdog in XFER
    set_req(0, mk(0, 'h10, 'hAAAA0000, 1));
    set_req(1, mk(1, 'h11, 'hBBBB1111, 1));
    exp_q.push_back(mk(1, 'h11, 'hBBBB1111, 1));
    waitrequest = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (write && n < 100) begin n++; tick(); end
    chk("wd_xfer_len", n, 16);
    chk("wd_xfer_err", {31'd0, timeout_err}, 1);
    chk("wd_xfer_busy", {31'd0, busy}, 0);
    tick();
    chk("wd_xfer_pulse", {31'd0, timeout_err}, 0);
    chk("wd_xfer_next", {29'd0, grant_id}, 1);
    chk("wd_xfer_next_wr", {31'd0, write}, 1);
    req_valid = '0;
    waitrequest = 1'b0;
    tick();
    chk("wd_xfer_done", {31'd0, busy}, 0);
    model_ptr = 2;

    // Watchdog in HOLD: non-last beat then requester goes silent
    set_req(2, mk(2, 'h20, 'hC0C0, 0));
    set_req(0, mk(0, 'h21, 'hD0D0, 1));
    exp_q.push_back(mk(2, 'h20, 'hC0C0, 0));
    exp_q.push_back(mk(0, 'h21, 'hD0D0, 1));
    tick();
    req_valid[2] = 1'b0;
    chk("wd_hold_first", {31'd0, write}, 1);
    tick();
    n = 0;
    while (!timeout_err && n < 100) begin
      if (busy && !write) n++;
      tick();
    end
    chk("wd_hold_len", n, 16);
    chk("wd_hold_busy", {31'd0, busy}, 0);
    chk("wd_hold_write", {31'd0, write}, 0);
    tick();
    chk("wd_hold_next", {29'd0, grant_id}, 0);
    chk("wd_hold_next_wr", {31'd0, write}, 1);
    req_valid = '0;
    tick();
    model_ptr = 1;

    // Async reset mid-XFER
    set_req(1, mk(1, 'h30, 'hE0E0, 1));
    waitrequest = 1'b1;
    tick();
    req_valid = '0;
    chk("arst_pre_write", {31'd0, write}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_write", {31'd0, write}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_grant", {29'd0, grant_id}, 0);
    chk("arst_addr", {23'd0, address}, 0);
    tick();
    waitrequest = 1'b0;
    reset_n = 1'b1;
    model_ptr = 0;
    rq[1].push_back(mk(1, 'h41, 'h4141, 1));
    rq[0].push_back(mk(0, 'h40, 'h4040, 1));
    run(0, 0, n, f, l);

    // Randomized backlog: varied burst lengths, HOLD gaps and waitrequest stalls
    for (int i = 0; i < 3; i++) begin
      nb = $urandom_range(2, 5);
      for (int b = 0; b < nb; b++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++)
          rq[i].push_back(mk(i, $urandom_range(0, 511), $urandom, j == len - 1));
      end
    end
    run(3, 30, n, f, l);
    chk("no_spurious_timeout", {31'd0, timeout_err}, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
